// File: rtl/rob_defs_pkg.sv
// Shared ROB entry layout, width constants and robid age helper for the retire stage.
package rob_defs;

    localparam int unsigned RET_WIDTH_MAX = 4;
    localparam int unsigned REG_W         = 5;
    localparam int unsigned NUM_REGS      = 32;
    localparam int unsigned TGT_MAX_W     = 64;
    localparam int unsigned ROBID_MAX_W   = 8;
    localparam int unsigned ROBID_IDX_W   = 3;

    typedef struct packed {
        logic                 vld;
        logic                 done;
        logic                 mispred;
        logic                 dst_vld;
        logic [REG_W-1:0]     dst;
        logic [TGT_MAX_W-1:0] tgt;
    } t_rob_entry;

    // True when robid a is strictly older than robid b; id_w is the index width below the wrap bit.
    function automatic logic robid_older(input logic [ROBID_MAX_W-1:0] a,
                                         input logic [ROBID_MAX_W-1:0] b,
                                         input int unsigned id_w);
        logic [ROBID_MAX_W-1:0] diff;
        diff = a - b;
        return diff[ROBID_IDX_W'(id_w)];
    endfunction

endpackage

// File: rtl/rob_reg_pdg_table.sv
// Per-architectural-register pending-producer table (x1..x31) with source lookup ports.
module rob_reg_pdg_table
    import rob_defs::*;
#(
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned RET_WIDTH = 2,
    parameter int unsigned RID_W     = 5
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  clear,
    input  logic                                  set_valid,
    input  logic [REG_W-1:0]                      set_reg,
    input  logic [RID_W-1:0]                      set_robid,
    input  logic [RET_WIDTH-1:0]                  clr_valid,
    input  logic [RET_WIDTH-1:0][REG_W-1:0]       clr_reg,
    input  logic [RET_WIDTH-1:0][RID_W-1:0]       clr_robid,
    input  logic [NUM_SRC-1:0][REG_W-1:0]         rd_addr,
    output logic [NUM_SRC-1:0]                    rd_pdg_c,
    output logic [NUM_SRC-1:0][RID_W-1:0]         rd_robid_c
);

    logic [NUM_REGS-1:1] pdg;
    logic [RID_W-1:0]    robid [1:NUM_REGS-1];

    // Retire clears only if the table still points at that producer; a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pdg <= '0;
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                robid[r] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < RET_WIDTH; k++) begin
                if (clr_valid[k] && (clr_reg[k] != '0) && (robid[clr_reg[k]] == clr_robid[k])) begin
                    pdg[clr_reg[k]] <= 1'b0;
                end
            end
            if (set_valid && (set_reg != '0)) begin
                pdg[set_reg]   <= 1'b1;
                robid[set_reg] <= set_robid;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            rd_pdg_c[i]   = 1'b0;
            rd_robid_c[i] = '0;
            if ((rd_addr[i] != '0) && pdg[rd_addr[i]]) begin
                rd_pdg_c[i]   = 1'b1;
                rd_robid_c[i] = robid[rd_addr[i]];
            end
        end
    end

endmodule

// File: rtl/retire_wide.sv
// In-order multi-lane retirement stage with integrated reorder buffer and mispredict flush.
module retire_wide
    import rob_defs::*;
#(
    parameter  int unsigned DEPTH     = 16,
    parameter  int unsigned RET_WIDTH = 2,
    parameter  int unsigned NUM_SRC   = 2,
    parameter  int unsigned PADDR_W   = 32,
    localparam int unsigned ID_W      = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alloc_valid_ra0,
    output logic                              alloc_ready_ra0,
    input  logic                              alloc_dst_vld_ra0,
    input  logic [REG_W-1:0]                  alloc_dst_ra0,
    output logic [ID_W:0]                     next_robid_ra0,
    input  logic [NUM_SRC-1:0][REG_W-1:0]     src_addr_ra0,
    output logic [NUM_SRC-1:0]                src_pdg_ra0,
    output logic [NUM_SRC-1:0][ID_W:0]        src_robid_ra0,
    input  logic                              wb_valid_rb0,
    input  logic [ID_W:0]                     wb_robid_rb0,
    input  logic                              wb_mispred_rb0,
    input  logic [PADDR_W-1:0]                wb_tgt_rb0,
    output logic [RET_WIDTH-1:0]              ret_valid_rb1,
    output logic [RET_WIDTH-1:0][ID_W:0]      ret_robid_rb1,
    output logic                              br_mispred_rb1,
    output logic [PADDR_W-1:0]                br_tgt_rb1
);

    localparam int unsigned RID_W = ID_W + 1;

    typedef logic [ID_W:0] t_robid;

    t_rob_entry rob [DEPTH];
    t_robid     head;
    t_robid     tail;

    logic                             full;
    logic                             alloc_fire;
    t_robid                           lane_id [RET_WIDTH];
    logic [RET_WIDTH-1:0]             sel;
    t_robid                           ret_cnt;
    logic                             grp_mispred;
    logic [TGT_MAX_W-1:0]             grp_tgt;
    logic [RET_WIDTH-1:0]             clr_valid;
    logic [RET_WIDTH-1:0][REG_W-1:0]  clr_reg;
    logic [RET_WIDTH-1:0][ID_W:0]     clr_robid;
    logic [ID_W-1:0]                  wb_idx;
    logic                             wb_in_window;
    logic                             wb_ok;

    assign full            = (head[ID_W-1:0] == tail[ID_W-1:0]) && (head[ID_W] != tail[ID_W]);
    assign alloc_ready_ra0 = !full && !br_mispred_rb1;
    assign alloc_fire      = alloc_valid_ra0 && alloc_ready_ra0;
    assign next_robid_ra0  = tail;

    // A writeback must name a live robid in [head, tail) of the current generation.
    assign wb_idx       = wb_robid_rb0[ID_W-1:0];
    assign wb_in_window = !robid_older(ROBID_MAX_W'(wb_robid_rb0), ROBID_MAX_W'(head), ID_W)
                        &&  robid_older(ROBID_MAX_W'(wb_robid_rb0), ROBID_MAX_W'(tail), ID_W);
    assign wb_ok        = wb_valid_rb0 && wb_in_window && rob[wb_idx].vld && !rob[wb_idx].done;

    // Retire group: contiguous done entries from head, closed by the first mispredicted one.
    always_comb begin
        logic stop;
        stop        = 1'b0;
        sel         = '0;
        ret_cnt     = '0;
        grp_mispred = 1'b0;
        grp_tgt     = '0;
        for (int unsigned k = 0; k < RET_WIDTH; k++) begin
            lane_id[k]   = head + RID_W'(k);
            clr_valid[k] = 1'b0;
            clr_reg[k]   = rob[lane_id[k][ID_W-1:0]].dst;
            clr_robid[k] = lane_id[k];
            if (!stop && rob[lane_id[k][ID_W-1:0]].vld && rob[lane_id[k][ID_W-1:0]].done) begin
                sel[k]       = 1'b1;
                ret_cnt      = RID_W'(k + 1);
                clr_valid[k] = rob[lane_id[k][ID_W-1:0]].dst_vld;
                if (rob[lane_id[k][ID_W-1:0]].mispred) begin
                    stop        = 1'b1;
                    grp_mispred = 1'b1;
                    grp_tgt     = rob[lane_id[k][ID_W-1:0]].tgt;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head           <= '0;
            tail           <= '0;
            ret_valid_rb1  <= '0;
            ret_robid_rb1  <= '0;
            br_mispred_rb1 <= 1'b0;
            br_tgt_rb1     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rob[i] <= '0;
            end
        end else begin
            ret_valid_rb1  <= sel;
            br_mispred_rb1 <= grp_mispred;
            br_tgt_rb1     <= grp_mispred ? grp_tgt[PADDR_W-1:0] : '0;
            for (int unsigned k = 0; k < RET_WIDTH; k++) begin
                ret_robid_rb1[k] <= sel[k] ? lane_id[k] : '0;
            end
            head <= head + ret_cnt;

            if (grp_mispred) begin
                // Everything younger than the mispredicted branch is wrong-path, including this cycle's alloc.
                tail <= head + ret_cnt;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    rob[i] <= '0;
                end
            end else begin
                for (int unsigned k = 0; k < RET_WIDTH; k++) begin
                    if (sel[k]) begin
                        rob[lane_id[k][ID_W-1:0]].vld <= 1'b0;
                    end
                end
                if (alloc_fire) begin
                    rob[tail[ID_W-1:0]] <= '{vld: 1'b1, done: 1'b0, mispred: 1'b0,
                                             dst_vld: alloc_dst_vld_ra0, dst: alloc_dst_ra0,
                                             tgt: '0};
                    tail <= tail + RID_W'(1);
                end
                if (wb_ok) begin
                    rob[wb_idx].done    <= 1'b1;
                    rob[wb_idx].mispred <= wb_mispred_rb0;
                    rob[wb_idx].tgt     <= TGT_MAX_W'(wb_tgt_rb0);
                end
            end
        end
    end

    rob_reg_pdg_table #(
        .NUM_SRC   (NUM_SRC),
        .RET_WIDTH (RET_WIDTH),
        .RID_W     (RID_W)
    ) u_pdg_table (
        .clk        (clk),
        .reset      (reset),
        .clear      (grp_mispred),
        .set_valid  (alloc_fire && alloc_dst_vld_ra0),
        .set_reg    (alloc_dst_ra0),
        .set_robid  (tail),
        .clr_valid  (clr_valid),
        .clr_reg    (clr_reg),
        .clr_robid  (clr_robid),
        .rd_addr    (src_addr_ra0),
        .rd_pdg_c   (src_pdg_ra0),
        .rd_robid_c (src_robid_ra0)
    );

    a_alloc_when_ready: assert property (@(posedge clk) disable iff (reset)
        alloc_valid_ra0 |-> alloc_ready_ra0);

    a_wb_live_entry: assert property (@(posedge clk) disable iff (reset)
        wb_valid_rb0 |-> wb_ok);

    // Targets are stored zero-extended, so the pad bits of a redirect target must stay clear.
    if (PADDR_W < TGT_MAX_W) begin : g_tgt_pad
        a_tgt_pad_zero: assert property (@(posedge clk) disable iff (reset)
            grp_tgt[TGT_MAX_W-1:PADDR_W] == '0);
    end

endmodule

// File: tb/tb_retire_wide.sv
// Directed self-checking bench for retire_wide (DEPTH=16, RET_WIDTH=2, NUM_SRC=2, PADDR_W=32).
module tb_retire_wide;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  alloc_valid_ra0;
    logic                  alloc_ready_ra0;
    logic                  alloc_dst_vld_ra0;
    logic [4:0]            alloc_dst_ra0;
    logic [4:0]            next_robid_ra0;
    logic [1:0][4:0]       src_addr_ra0;
    logic [1:0]            src_pdg_ra0;
    logic [1:0][4:0]       src_robid_ra0;
    logic                  wb_valid_rb0;
    logic [4:0]            wb_robid_rb0;
    logic                  wb_mispred_rb0;
    logic [31:0]           wb_tgt_rb0;
    logic [1:0]            ret_valid_rb1;
    logic [1:0][4:0]       ret_robid_rb1;
    logic                  br_mispred_rb1;
    logic [31:0]           br_tgt_rb1;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;

    retire_wide #(
        .DEPTH     (16),
        .RET_WIDTH (2),
        .NUM_SRC   (2),
        .PADDR_W   (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .alloc_valid_ra0   (alloc_valid_ra0),
        .alloc_ready_ra0   (alloc_ready_ra0),
        .alloc_dst_vld_ra0 (alloc_dst_vld_ra0),
        .alloc_dst_ra0     (alloc_dst_ra0),
        .next_robid_ra0    (next_robid_ra0),
        .src_addr_ra0      (src_addr_ra0),
        .src_pdg_ra0       (src_pdg_ra0),
        .src_robid_ra0     (src_robid_ra0),
        .wb_valid_rb0      (wb_valid_rb0),
        .wb_robid_rb0      (wb_robid_rb0),
        .wb_mispred_rb0    (wb_mispred_rb0),
        .wb_tgt_rb0        (wb_tgt_rb0),
        .ret_valid_rb1     (ret_valid_rb1),
        .ret_robid_rb1     (ret_robid_rb1),
        .br_mispred_rb1    (br_mispred_rb1),
        .br_tgt_rb1        (br_tgt_rb1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic alloc(input logic dv, input logic [4:0] dst);
        alloc_valid_ra0   = 1'b1;
        alloc_dst_vld_ra0 = dv;
        alloc_dst_ra0     = dst;
        step();
        alloc_valid_ra0   = 1'b0;
        alloc_dst_vld_ra0 = 1'b0;
        alloc_dst_ra0     = '0;
    endtask

    task automatic wb(input logic [4:0] id, input logic mp, input logic [31:0] tgt);
        wb_valid_rb0   = 1'b1;
        wb_robid_rb0   = id;
        wb_mispred_rb0 = mp;
        wb_tgt_rb0     = tgt;
        step();
        wb_valid_rb0   = 1'b0;
        wb_robid_rb0   = '0;
        wb_mispred_rb0 = 1'b0;
        wb_tgt_rb0     = '0;
    endtask

    task automatic lookup(input logic [4:0] a0, input logic [4:0] a1);
        src_addr_ra0[0] = a0;
        src_addr_ra0[1] = a1;
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".ready"},     64'(alloc_ready_ra0), 64'd1);
        chk({tag, ".next"},      64'(next_robid_ra0),  64'd0);
        chk({tag, ".src_pdg"},   64'(src_pdg_ra0),     64'd0);
        chk({tag, ".src_robid"}, 64'(src_robid_ra0),   64'd0);
        chk({tag, ".ret_valid"}, 64'(ret_valid_rb1),   64'd0);
        chk({tag, ".ret_robid"}, 64'(ret_robid_rb1),   64'd0);
        chk({tag, ".br"},        64'(br_mispred_rb1),  64'd0);
        chk({tag, ".br_tgt"},    64'(br_tgt_rb1),      64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset             = 1'b1;
        alloc_valid_ra0   = 1'b0;
        alloc_dst_vld_ra0 = 1'b0;
        alloc_dst_ra0     = '0;
        src_addr_ra0      = '0;
        wb_valid_rb0      = 1'b0;
        wb_robid_rb0      = '0;
        wb_mispred_rb0    = 1'b0;
        wb_tgt_rb0        = '0;

        // Reset values; x1/x2 looked up against an empty table.
        do_reset();
        lookup(5'd1, 5'd2);
        chk_reset_state("rst");

        // Three producers, in-order writeback one per cycle.
        do_reset();
        alloc(1'b1, 5'd1);
        lookup(5'd1, 5'd0);
        chk("t1.pdg_x1",   64'(src_pdg_ra0),      64'b01);
        chk("t1.robid_x1", 64'(src_robid_ra0[0]), 64'd0);
        chk("t1.next",     64'(next_robid_ra0),   64'd1);
        alloc(1'b1, 5'd2);
        alloc(1'b1, 5'd3);
        lookup(5'd1, 5'd3);
        chk("t1.pdg_x1x3",  64'(src_pdg_ra0),      64'b11);
        chk("t1.robid_x3",  64'(src_robid_ra0[1]), 64'd2);
        wb(5'd0, 1'b0, 32'h0);
        chk("t1.ret_none",  64'(ret_valid_rb1),    64'b00);
        wb(5'd1, 1'b0, 32'h0);
        chk("t1.ret0_v",    64'(ret_valid_rb1),    64'b01);
        chk("t1.ret0_id",   64'(ret_robid_rb1[0]), 64'd0);
        wb(5'd2, 1'b0, 32'h0);
        chk("t1.ret1_v",    64'(ret_valid_rb1),    64'b01);
        chk("t1.ret1_id",   64'(ret_robid_rb1[0]), 64'd1);
        step();
        chk("t1.ret2_v",    64'(ret_valid_rb1),    64'b01);
        chk("t1.ret2_id",   64'(ret_robid_rb1[0]), 64'd2);
        lookup(5'd1, 5'd3);
        chk("t1.pdg_clr",   64'(src_pdg_ra0),      64'b00);
        step();
        chk("t1.idle",      64'(ret_valid_rb1),    64'b00);
        chk("t1.next_end",  64'(next_robid_ra0),   64'd3);

        // Fill to 16, then free one slot by retiring id 0.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(1'b0, 5'd0);
        end
        chk("t2.full_ready", 64'(alloc_ready_ra0), 64'd0);
        chk("t2.full_next",  64'(next_robid_ra0),  64'h10);
        wb(5'd0, 1'b0, 32'h0);
        chk("t2.full_retiring_ready", 64'(alloc_ready_ra0), 64'd0);
        step();
        chk("t2.ret_v",      64'(ret_valid_rb1),    64'b01);
        chk("t2.ret_id",     64'(ret_robid_rb1[0]), 64'd0);
        chk("t2.freed_ready", 64'(alloc_ready_ra0), 64'd1);
        chk("t2.wrap_next",  64'(next_robid_ra0),   64'h10);
        alloc(1'b0, 5'd0);
        chk("t2.next_after", 64'(next_robid_ra0),   64'h11);
        chk("t2.full_again", 64'(alloc_ready_ra0),  64'd0);

        // Out-of-order writeback 2,1,0.
        do_reset();
        alloc(1'b0, 5'd0);
        alloc(1'b0, 5'd0);
        alloc(1'b0, 5'd0);
        wb(5'd2, 1'b0, 32'h0);
        chk("t3.hold_a", 64'(ret_valid_rb1), 64'b00);
        wb(5'd1, 1'b0, 32'h0);
        chk("t3.hold_b", 64'(ret_valid_rb1), 64'b00);
        wb(5'd0, 1'b0, 32'h0);
        chk("t3.hold_c", 64'(ret_valid_rb1), 64'b00);
        step();
        chk("t3.grp_v",  64'(ret_valid_rb1), 64'b11);
        chk("t3.grp_id", 64'(ret_robid_rb1), 64'h020);
        step();
        chk("t3.last_v",  64'(ret_valid_rb1), 64'b01);
        chk("t3.last_id", 64'(ret_robid_rb1), 64'h002);
        step();
        chk("t3.empty",  64'(ret_valid_rb1), 64'b00);

        // Mispredicted id 4 closes the group ahead of a done id 5.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc(1'b0, 5'd0);
        end
        wb(5'd0, 1'b0, 32'h0);
        wb(5'd1, 1'b0, 32'h0);
        wb(5'd2, 1'b0, 32'h0);
        wb(5'd3, 1'b0, 32'h0);
        wb(5'd5, 1'b0, 32'h0);
        chk("t4.ret3_id", 64'(ret_robid_rb1[0]), 64'd3);
        wb(5'd4, 1'b1, 32'h8000_0040);
        chk("t4.wait4",   64'(ret_valid_rb1), 64'b00);
        alloc(1'b1, 5'd7);
        chk("t4.br_v",     64'(ret_valid_rb1),  64'b01);
        chk("t4.br_id",    64'(ret_robid_rb1),  64'h004);
        chk("t4.br",       64'(br_mispred_rb1), 64'd1);
        chk("t4.br_tgt",   64'(br_tgt_rb1),     64'h8000_0040);
        chk("t4.br_ready", 64'(alloc_ready_ra0), 64'd0);
        chk("t4.br_next",  64'(next_robid_ra0),  64'd5);
        lookup(5'd7, 5'd0);
        chk("t4.flush_pdg", 64'(src_pdg_ra0),   64'b00);
        step();
        chk("t4.pulse_end", 64'(br_mispred_rb1), 64'd0);
        chk("t4.post_ret",  64'(ret_valid_rb1),  64'b00);
        chk("t4.post_ready", 64'(alloc_ready_ra0), 64'd1);
        chk("t4.post_next", 64'(next_robid_ra0),  64'd5);

        // Two writers of x5: retiring the older one leaves the younger pending.
        do_reset();
        alloc(1'b1, 5'd5);
        alloc(1'b1, 5'd5);
        lookup(5'd5, 5'd0);
        chk("t5.pdg",    64'(src_pdg_ra0),      64'b01);
        chk("t5.robid",  64'(src_robid_ra0[0]), 64'd1);
        wb(5'd0, 1'b0, 32'h0);
        step();
        chk("t5.ret0",   64'(ret_robid_rb1[0]), 64'd0);
        lookup(5'd5, 5'd0);
        chk("t5.still_pdg",   64'(src_pdg_ra0),      64'b01);
        chk("t5.still_robid", 64'(src_robid_ra0[0]), 64'd1);
        wb(5'd1, 1'b0, 32'h0);
        step();
        lookup(5'd5, 5'd0);
        chk("t5.cleared", 64'(src_pdg_ra0), 64'b00);

        // Reset with six in flight and a mispredict about to retire.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            alloc(1'b1, 5'(i + 1));
        end
        wb(5'd0, 1'b0, 32'h0);
        wb(5'd1, 1'b0, 32'h0);
        chk("t6.busy", 64'(ret_valid_rb1), 64'b01);
        wb(5'd2, 1'b1, 32'h0000_1234);
        do_reset();
        lookup(5'd2, 5'd6);
        chk_reset_state("t6");
        step();
        chk("t6.no_redirect", 64'(br_mispred_rb1), 64'd0);
        chk("t6.no_retire",   64'(ret_valid_rb1),  64'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
